// File: rtl/id_exe_pipe.sv
// Decode-to-execute two-entry skid buffer. All outputs are driven from flops;
// flush kills both entries but a retire in the flush cycle still completes.
module id_exe_pipe #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OP_W   = 10,
    parameter int unsigned ALU_W  = 12,
    parameter int unsigned BJ_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_inst_type,
    input  logic [7:0]        in_opcode,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic              in_is_word,
    input  logic [OP_W-1:0]   in_op_info,
    input  logic [ALU_W-1:0]  in_alu_info,
    input  logic [BJ_W-1:0]   in_bj_info,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_inst_type,
    output logic [7:0]        out_opcode,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic              out_is_word,
    output logic [OP_W-1:0]   out_op_info,
    output logic [ALU_W-1:0]  out_alu_info,
    output logic [BJ_W-1:0]   out_bj_info
);

    localparam int unsigned PW = 5 + 8 + 2 * DATA_W + 1 + OP_W + ALU_W + BJ_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_main_pl;
    logic [PW-1:0]   r_skid_pl;
    logic [PW-1:0]   w_in_pl;
    logic            r_out_valid;
    logic            r_in_ready;
    logic            w_accept;
    logic            w_retire;
    logic            w_load_main_in;
    logic            w_load_main_skid;
    logic            w_load_skid;

    assign w_in_pl  = {in_inst_type, in_opcode, in_op1, in_op2, in_is_word,
                       in_op_info, in_alu_info, in_bj_info};
    assign w_accept = in_valid && r_in_ready;
    assign w_retire = r_out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_retire) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_TWO;
                end else if (w_retire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_retire) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = S_ONE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
        // Flush wins: same-cycle accepts are dropped, payload left as-is.
        if (flush) begin
            w_state_nxt      = S_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_pl   <= '0;
            r_skid_pl   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != S_EMPTY);
            r_in_ready  <= (w_state_nxt != S_TWO);
            if (w_load_main_in) begin
                r_main_pl <= w_in_pl;
            end else if (w_load_main_skid) begin
                r_main_pl <= r_skid_pl;
            end
            if (w_load_skid) begin
                r_skid_pl <= w_in_pl;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign {out_inst_type, out_opcode, out_op1, out_op2, out_is_word,
            out_op_info, out_alu_info, out_bj_info} = r_main_pl;

endmodule

// File: tb/tb_id_exe_pipe.sv
// Scoreboard bench for id_exe_pipe: stimulus queues expected bundles on
// accept, a negedge monitor pops and compares on every retire.
module tb_id_exe_pipe;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned OP_W   = 10;
    localparam int unsigned ALU_W  = 12;
    localparam int unsigned BJ_W   = 6;
    localparam int unsigned PW     = 5 + 8 + 2 * DATA_W + 1 + OP_W + ALU_W + BJ_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_inst_type;
    logic [7:0]        in_opcode;
    logic [DATA_W-1:0] in_op1;
    logic [DATA_W-1:0] in_op2;
    logic              in_is_word;
    logic [OP_W-1:0]   in_op_info;
    logic [ALU_W-1:0]  in_alu_info;
    logic [BJ_W-1:0]   in_bj_info;
    logic              out_valid;
    logic              out_ready;
    logic [4:0]        out_inst_type;
    logic [7:0]        out_opcode;
    logic [DATA_W-1:0] out_op1;
    logic [DATA_W-1:0] out_op2;
    logic              out_is_word;
    logic [OP_W-1:0]   out_op_info;
    logic [ALU_W-1:0]  out_alu_info;
    logic [BJ_W-1:0]   out_bj_info;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [PW-1:0] exp_q[$];
    logic          last_acc;

    id_exe_pipe #(.DATA_W(DATA_W), .OP_W(OP_W), .ALU_W(ALU_W), .BJ_W(BJ_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst_type(in_inst_type), .in_opcode(in_opcode),
        .in_op1(in_op1), .in_op2(in_op2), .in_is_word(in_is_word),
        .in_op_info(in_op_info), .in_alu_info(in_alu_info), .in_bj_info(in_bj_info),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst_type(out_inst_type), .out_opcode(out_opcode),
        .out_op1(out_op1), .out_op2(out_op2), .out_is_word(out_is_word),
        .out_op_info(out_op_info), .out_alu_info(out_alu_info), .out_bj_info(out_bj_info)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] in_bundle();
        return {in_inst_type, in_opcode, in_op1, in_op2, in_is_word,
                in_op_info, in_alu_info, in_bj_info};
    endfunction

    // Monitor: every retire must match the oldest expected bundle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [PW-1:0] got;
            got = {out_inst_type, out_opcode, out_op1, out_op2, out_is_word,
                   out_op_info, out_alu_info, out_bj_info};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL retire_unexpected: got op1=%h, required no output", out_op1);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL retire_payload: got %h, required %h", got, e);
                end
            end
        end
    end

    // One clock: note accept at negedge, update the model, return #1 after posedge.
    task automatic tick();
        logic [PW-1:0] b;
        @(negedge clk);
        last_acc = in_valid && in_ready && !rst;
        b = in_bundle();
        #1;
        if (flush || rst) exp_q.delete();
        else if (last_acc) exp_q.push_back(b);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic set_in(input logic v, input logic [63:0] op1);
        in_valid     = v;
        in_op1       = op1;
        in_op2       = ~op1;
        in_opcode    = op1[7:0] ^ 8'h5A;
        in_inst_type = op1[4:0];
        in_is_word   = op1[0];
        in_op_info   = OP_W'(op1 * 3);
        in_alu_info  = ALU_W'(op1 * 7);
        in_bj_info   = BJ_W'(op1 + 1);
    endtask

    task automatic drain();
        set_in(1'b0, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 64'd0);
        tick(); tick();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_op1", out_op1, 64'd0);
        check("reset_opcode", 64'(out_opcode), 64'd0);
        rst = 1'b0;

        // Streaming 1..8 back to back
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b1, 64'(i));
            tick();
            check("stream_in_ready", 64'(in_ready), 64'd1);
            if (i == 1) begin
                check("stream_first_valid", 64'(out_valid), 64'd1);
                check("stream_first_op1", out_op1, 64'd1);
            end
        end
        drain();

        // Backpressure: A, B fill both entries, C held off
        out_ready = 1'b0;
        set_in(1'b1, 64'hA); tick();
        check("bp_ready_after_A", 64'(in_ready), 64'd1);
        set_in(1'b1, 64'hB); tick();
        check("bp_ready_after_B", 64'(in_ready), 64'd0);
        set_in(1'b1, 64'hC); tick();
        check("bp_C_held", 64'(last_acc), 64'd0);
        check("bp_main_A", out_op1, 64'hA);
        out_ready = 1'b1;
        last_acc = 1'b0;
        for (int i = 0; i < 10 && !last_acc; i++) tick();
        check("bp_C_accepted", 64'(last_acc), 64'd1);
        drain();

        // Flush while holding A, B; C offered in the flush cycle
        out_ready = 1'b0;
        set_in(1'b1, 64'hA); tick();
        set_in(1'b1, 64'hB); tick();
        set_in(1'b1, 64'hC); flush = 1'b1; tick();
        flush = 1'b0; set_in(1'b0, 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1; tick(); tick();
        check("flush_no_output", 64'(out_valid), 64'd0);

        // Simultaneous accept and retire in ONE
        out_ready = 1'b0;
        set_in(1'b1, 64'hA); tick();
        out_ready = 1'b1;
        set_in(1'b1, 64'hD); tick();
        check("sim_op1_D", out_op1, 64'hD);
        check("sim_in_ready", 64'(in_ready), 64'd1);
        set_in(1'b0, 64'd0); tick();
        check("sim_skid_empty", 64'(out_valid), 64'd0);

        // Payload fidelity
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst_type = 5'h13; in_opcode = 8'hC3;
        in_op1 = 64'h0123_4567_89AB_CDEF; in_op2 = 64'hFFFF_FFFF_8000_0000;
        in_is_word = 1'b1; in_op_info = 10'h2A5; in_alu_info = 12'hB3C; in_bj_info = 6'h29;
        tick();
        set_in(1'b0, 64'd0);
        check("pl_inst_type", 64'(out_inst_type), 64'h13);
        check("pl_opcode", 64'(out_opcode), 64'hC3);
        check("pl_op1", out_op1, 64'h0123_4567_89AB_CDEF);
        check("pl_op2", out_op2, 64'hFFFF_FFFF_8000_0000);
        check("pl_is_word", 64'(out_is_word), 64'd1);
        check("pl_op_info", 64'(out_op_info), 64'h2A5);
        check("pl_alu_info", 64'(out_alu_info), 64'hB3C);
        check("pl_bj_info", 64'(out_bj_info), 64'h29);
        tick();
        check("pl_stable", out_op2, 64'hFFFF_FFFF_8000_0000);
        drain();

        // Mid-operation reset zeroes payload and empties buffer
        out_ready = 1'b0;
        set_in(1'b1, 64'h77); tick();
        set_in(1'b0, 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_op1", out_op1, 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, required finish before 50000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_exe_pipe.md
# id_exe_pipe

Registered two-entry skid buffer that hands decoded instructions from the decode stage to `exe_stage`. It is the sending end of the execute-operand interface. It latches the operand and control bundle, presents it to execute with a valid/ready handshake, and drops in-flight instructions when a taken branch/jump flushes the front end. All outputs come straight from flops, so the decode-to-execute path is fully timing-isolated.

## Interface
- DATA_W, 64, operand width; matches `REG_BUS`.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- flush  in  1  taken branch/jump from execute (`bj_ena`); kills all buffered entries.
- in_valid  in  1  decode presents a bundle.
- in_ready  out  1  buffer can accept; registered, equals "skid entry empty".
- in_inst_type  in  5  instruction type.
- in_opcode  in  8  instruction opcode.
- in_op1, in_op2  in  DATA_W  source operands.
- in_is_word  in  1  32-bit (W-suffix) operation.
- in_op_info  in  `OP_BUS`  operation info.
- in_alu_info  in  `ALU_BUS`  ALU control.
- in_bj_info  in  `BJ_BUS`  branch/jump control.
- out_valid  out  1  execute bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_inst_type, out_opcode, out_op1, out_op2, out_is_word, out_op_info, out_alu_info, out_bj_info  out  same widths as inputs  registered bundle to execute.

## Operation
- Storage: main entry (drives out_*) and skid entry, each with a valid bit. Occupancy state: EMPTY (neither valid), ONE (main only), TWO (both).
- Accept when in_valid && in_ready. Retire when out_valid && out_ready.
- EMPTY: accept -> main, go to ONE.
- ONE:
  - accept && retire -> main reloads from input, stay in ONE.
  - accept && !retire -> input goes to skid, go to TWO.
  - retire && !accept -> go to EMPTY.
  - neither -> hold.
- TWO: in_ready=0, so no accept. On retire, skid moves to main and state goes to ONE. Otherwise hold.
- Order is strict FIFO. A bundle never overtakes an older one and is never duplicated.
- Flush has priority over everything. Next state is EMPTY and any bundle accepted in the same cycle is discarded. Payload registers need not clear; only the valid bits clear.
- A retire in the flush cycle still completes, because execute consumed it combinationally.
- out_* payload is stable while out_valid && !out_ready.
- Reset: state EMPTY, out_valid=0, in_ready=1, every out_* payload = 0.
- Widths: payload passes through bit-exact. No arithmetic, sign extension or truncation here; is_word handling stays in execute.

## Timing
- Latency: bundle accepted at edge N appears on out_* with out_valid=1 after edge N (cycle N+1) when the buffer was EMPTY.
- Throughput: 1 bundle/cycle while out_ready=1. in_ready stays 1 in state ONE when a retire happens every cycle.
- in_ready drops the cycle after the skid entry fills. It rises the cycle after the skid drains or a flush occurs.
- No combinational path from out_ready or flush to in_ready or out_*.
- Reset mid-operation behaves exactly like flush and also zeroes the payload. The first accept after reset is at the edge where rst=0.

## Test plan
- Reset: hold rst 2 cycles, release -> out_valid=0, in_ready=1, out_op1=0, out_opcode=0.
- Streaming: send 8 bundles with out_op1=1..8 back-to-back, out_ready=1 -> out_valid from cycle 1, values 1..8 in order, one per cycle, in_ready never 0.
- Backpressure: out_ready=0, send A (op1=0xA) then B (op1=0xB) -> in_ready=0 after B; third bundle C held off. Raise out_ready -> A, B, C retire in order with no loss.
- Flush in TWO: buffer holds A, B with out_ready=0; assert flush with in_valid (C) -> next cycle out_valid=0, in_ready=1; C is never output.
- Simultaneous accept and retire in ONE: main=A, out_ready=1, in_valid with D (op1=0xD) -> next cycle out_op1=0xD, state ONE, skid empty.
- Payload fidelity: in_op2=0xFFFF_FFFF_8000_0000, in_is_word=1, arbitrary alu/bj info -> identical bits on out_* one cycle later.
